diffeq_job_scheduler: RTL and testbench

- Shares one differentiator engine between NUM_REQ requesters.
- Round-robin arbitration; operands of the granted requester are snapshotted at grant.
- Drives the engine's four-step nibble load sequence (x, dx, u, a), waits for the engine's valid, then returns the 16-bit result to the owning requester with a done pulse.
- Sits between requester-side job logic and a single differentiator instance.

---
 rtl/diffeq_sched_pkg.sv | 26 ++
 rtl/diffeq_job_scheduler_rr_arbiter.sv | 41 ++++
 rtl/diffeq_job_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_diffeq_job_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diffeq_sched_pkg.sv
// Shared definitions for the differentiator job scheduler.
//   sched_state_t : scheduler FSM state encoding (3 bits)
//   nibble_t      : one engine operand nibble
//   RESULT_W      : width of the engine result
//   wrap_add      : (base + off) modulo n, used for round-robin index arithmetic
package diffeq_sched_pkg;

  localparam int RESULT_W = 16;

  typedef logic [3:0] nibble_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_X  = 3'd1,
    LD_DX = 3'd2,
    LD_U  = 3'd3,
    LD_A  = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } sched_state_t;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/diffeq_job_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
// Grants the first set req bit at or after pointer, wrapping modulo NUM_REQ.
// Ports:
//   req     in  NUM_REQ  request vector
//   pointer in  IDX_W    index with highest priority this round
//   gnt     out NUM_REQ  one-hot grant (zero when no request)
//   idx     out IDX_W    encoded index of the granted requester
//   any     out 1        at least one request is pending
module rr_arbiter
  import diffeq_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(wrap_add(int'(pointer), k, NUM_REQ));
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/diffeq_job_scheduler.sv
// diffeq_job_scheduler: shares one differentiator engine between NUM_REQ
// requesters. A round-robin winner is granted from IDLE, its operands are
// snapshotted, the engine is loaded x, dx, u, a over four cycles, and the
// engine result is returned to the owner with a one-cycle done pulse.
//
// Optional feature macro: DIFF_SCHED_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYCLES, pulsing eng_reset and
//               err_timeout alongside done, with result forced to 0.
//   undefined : WAIT leaves only on eng_valid; eng_reset/err_timeout tied 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req                        per-requester level request, held until done
//   req_x/req_dx/req_u/req_a   packed operand nibbles, requester i at [4i+3:4i]
//   gnt                        one-hot grant pulse, operands captured this cycle
//   done                       one-hot completion pulse to the job owner
//   result                     last completed result, held until next done
//   err_timeout                abort flag, coincident with done
//   busy                       high in every state except IDLE
//   eng_reset                  engine reset pulse on abort
//   eng_ready, eng_s1..eng_s4  engine load strobe and operand selects
//   eng_in                     engine operand nibble
//   eng_out, eng_valid         engine result and its valid flag
module diffeq_job_scheduler
  import diffeq_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [4*NUM_REQ-1:0]  req_x,
  input  logic [4*NUM_REQ-1:0]  req_dx,
  input  logic [4*NUM_REQ-1:0]  req_u,
  input  logic [4*NUM_REQ-1:0]  req_a,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [RESULT_W-1:0]   result,
  output logic                  err_timeout,
  output logic                  busy,
  output logic                  eng_reset,
  output logic                  eng_ready,
  output logic                  eng_s1,
  output logic                  eng_s2,
  output logic                  eng_s3,
  output logic                  eng_s4,
  output logic [3:0]            eng_in,
  input  logic [RESULT_W-1:0]   eng_out,
  input  logic                  eng_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t     state;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] owner;
  nibble_t          dx_q, u_q, a_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  nibble_t            cap_x, cap_dx, cap_u, cap_a;
  logic [NUM_REQ-1:0] owner_onehot;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .pointer (pointer),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  // Operands of the arbitration winner, captured on the IDLE exit edge.
  assign cap_x  = req_x [{arb_idx, 2'b00} +: 4];
  assign cap_dx = req_dx[{arb_idx, 2'b00} +: 4];
  assign cap_u  = req_u [{arb_idx, 2'b00} +: 4];
  assign cap_a  = req_a [{arb_idx, 2'b00} +: 4];

  assign owner_onehot = NUM_REQ'(1) << owner;

  // The grant must coincide with the capture edge, so it is decoded from the
  // IDLE state; gating with reset keeps it low while reset is held.
  assign gnt  = (state == IDLE && !reset) ? arb_gnt : '0;
  assign busy = (state != IDLE);

`ifdef DIFF_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            eng_rst_q;

  assign err_timeout = err_q;
  assign eng_reset   = eng_rst_q;
`else
  assign err_timeout = 1'b0;
  assign eng_reset   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pointer   <= '0;
      owner     <= '0;
      dx_q      <= '0;
      u_q       <= '0;
      a_q       <= '0;
      result    <= '0;
      done      <= '0;
      eng_ready <= 1'b0;
      eng_s1    <= 1'b0;
      eng_s2    <= 1'b0;
      eng_s3    <= 1'b0;
      eng_s4    <= 1'b0;
      eng_in    <= '0;
`ifdef DIFF_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
      eng_rst_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            owner     <= arb_idx;
            dx_q      <= cap_dx;
            u_q       <= cap_u;
            a_q       <= cap_a;
            // x goes straight into the engine register; no separate copy.
            eng_ready <= 1'b1;
            eng_s1    <= 1'b1;
            eng_in    <= cap_x;
            state     <= LD_X;
          end
        end

        LD_X: begin
          eng_s1 <= 1'b0;
          eng_s2 <= 1'b1;
          eng_in <= dx_q;
          state  <= LD_DX;
        end

        LD_DX: begin
          eng_s2 <= 1'b0;
          eng_s3 <= 1'b1;
          eng_in <= u_q;
          state  <= LD_U;
        end

        LD_U: begin
          eng_s3 <= 1'b0;
          eng_s4 <= 1'b1;
          eng_in <= a_q;
          state  <= LD_A;
        end

        LD_A: begin
          eng_ready <= 1'b0;
          eng_s4    <= 1'b0;
          eng_in    <= '0;
`ifdef DIFF_SCHED_TIMEOUT_EN
          to_cnt    <= '0;
`endif
          state     <= WAIT;
        end

        WAIT: begin
          // A valid result arriving on the expiry cycle takes priority.
          if (eng_valid) begin
            result <= eng_out;
            done   <= owner_onehot;
            state  <= DONE;
          end
`ifdef DIFF_SCHED_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            result    <= '0;
            done      <= owner_onehot;
            err_q     <= 1'b1;
            eng_rst_q <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        DONE: begin
          done    <= '0;
          pointer <= IDX_W'(wrap_add(int'(owner), 1, NUM_REQ));
`ifdef DIFF_SCHED_TIMEOUT_EN
          err_q     <= 1'b0;
          eng_rst_q <= 1'b0;
`endif
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_job_scheduler.sv
// Directed testbench for diffeq_job_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=16).
// The bench plays the engine: it watches the load sequence and returns
// eng_valid/eng_out after a chosen number of WAIT cycles.
module tb_diffeq_job_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_x, req_dx, req_u, req_a;
  logic [NUM_REQ-1:0]   gnt, done;
  logic [15:0]          result;
  logic                 err_timeout, busy, eng_reset, eng_ready;
  logic                 eng_s1, eng_s2, eng_s3, eng_s4;
  logic [3:0]           eng_in;
  logic [15:0]          eng_out;
  logic                 eng_valid;

  logic [35:0] all_out;
  assign all_out = {gnt, done, result, err_timeout, busy, eng_reset, eng_ready,
                    eng_s1, eng_s2, eng_s3, eng_s4, eng_in};

  int pass_cnt  = 0;
  int total_cnt = 0;

  diffeq_job_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_x       (req_x),
    .req_dx      (req_dx),
    .req_u       (req_u),
    .req_a       (req_a),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .err_timeout (err_timeout),
    .busy        (busy),
    .eng_reset   (eng_reset),
    .eng_ready   (eng_ready),
    .eng_s1      (eng_s1),
    .eng_s2      (eng_s2),
    .eng_s3      (eng_s3),
    .eng_s4      (eng_s4),
    .eng_in      (eng_in),
    .eng_out     (eng_out),
    .eng_valid   (eng_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] x, input logic [3:0] dx,
                         input logic [3:0] u, input logic [3:0] a);
    req_x [4*i +: 4] = x;
    req_dx[4*i +: 4] = dx;
    req_u [4*i +: 4] = u;
    req_a [4*i +: 4] = a;
  endtask

  // Serves one job from grant to the idle cycle after done. Entered in the
  // cycle where req has just been driven; returns in the first IDLE cycle.
  task automatic serve_job(input string tag, input logic [3:0] exp_gnt,
                           input logic [3:0] x, input logic [3:0] dx,
                           input logic [3:0] u, input logic [3:0] a,
                           input int lat, input logic [15:0] val,
                           input bit mutate, output int wait_cycles);
    logic [3:0] nib [4];
    logic [3:0] sel;
    nib[0] = x; nib[1] = dx; nib[2] = u; nib[3] = a;
    wait_cycles = 0;
    #1;
    while (gnt == '0 && wait_cycles < 40) begin
      step();
      wait_cycles++;
    end
    total_cnt++;
    if (gnt !== exp_gnt)
      $display("FAIL %s grant: got %b expected %b", tag, gnt, exp_gnt);
    else pass_cnt++;

    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0 && mutate) begin
        req_x = '1; req_dx = '1; req_u = '1; req_a = '1; req = '0;
      end
      sel = 4'(1 << k);
      total_cnt++;
      if ({eng_ready, eng_s4, eng_s3, eng_s2, eng_s1, eng_in, gnt} !==
          {1'b1, sel, nib[k], 4'b0000})
        $display("FAIL %s load%0d: got rdy=%b sel=%b in=%h gnt=%b expected rdy=1 sel=%b in=%h gnt=0000",
                 tag, k, eng_ready, {eng_s4, eng_s3, eng_s2, eng_s1}, eng_in, gnt, sel, nib[k]);
      else pass_cnt++;
    end

    for (int k = 1; k <= lat; k++) begin
      step();
      total_cnt++;
      if ({done, busy, gnt, eng_ready, eng_s1, eng_s2, eng_s3, eng_s4, eng_in} !==
          {4'b0000, 1'b1, 4'b0000, 5'b00000, 4'h0})
        $display("FAIL %s wait%0d: got done=%b busy=%b gnt=%b rdy=%b in=%h expected done=0000 busy=1 gnt=0000 rdy=0 in=0",
                 tag, k, done, busy, gnt, eng_ready, eng_in);
      else pass_cnt++;
      if (k == lat) begin
        eng_valid = 1'b1;
        eng_out   = val;
      end
    end

    step();
    eng_valid = 1'b0;
    eng_out   = '0;
    total_cnt++;
    if ({done, result, err_timeout, eng_reset, busy} !== {exp_gnt, val, 1'b0, 1'b0, 1'b1})
      $display("FAIL %s done: got done=%b result=%h err=%b eng_reset=%b busy=%b expected done=%b result=%h err=0 eng_reset=0 busy=1",
               tag, done, result, err_timeout, eng_reset, busy, exp_gnt, val);
    else pass_cnt++;

    step();
    total_cnt++;
    if ({done, busy, result} !== {4'b0000, 1'b0, val})
      $display("FAIL %s idle: got done=%b busy=%b result=%h expected done=0000 busy=0 result=%h",
               tag, done, busy, result, val);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    req_x = '0; req_dx = '0; req_u = '0; req_a = '0;
    eng_out = 16'hFFFF; eng_valid = 1'b1;
    step();
    step();
    total_cnt++;
    if (all_out !== 36'd0)
      $display("FAIL reset_outputs: got %h expected 000000000", all_out);
    else pass_cnt++;
    req = '0;
    eng_valid = 1'b0;
    eng_out = '0;
    reset = 1'b0;
    step();
    // eng_valid while IDLE must not produce a done.
    eng_valid = 1'b1;
    eng_out = 16'h1234;
    step();
    step();
    total_cnt++;
    if ({done, busy, result} !== {4'b0000, 1'b0, 16'h0000})
      $display("FAIL idle_valid_ignored: got done=%b busy=%b result=%h expected done=0000 busy=0 result=0000",
               done, busy, result);
    else pass_cnt++;
    eng_valid = 1'b0;
    eng_out = '0;
    step();
  endtask

  task automatic test_round_robin();
    int order [5];
    int wc;
    int o;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int i = 0; i < NUM_REQ; i++)
      set_ops(i, 4'(i + 1), 4'(i + 5), 4'(i + 9), 4'(i + 12));
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      o = order[j];
      serve_job($sformatf("rr%0d", j), 4'(1 << o), 4'(o + 1), 4'(o + 5), 4'(o + 9),
                4'(o + 12), j + 1, 16'hA000 | 16'(j), 1'b0, wc);
      total_cnt++;
      if (wc !== 0)
        $display("FAIL rr%0d gap: got %0d idle cycles before grant expected 0", j, wc);
      else pass_cnt++;
    end
    req = '0;
    step();
  endtask

  task automatic test_single_job();
    int wc;
    set_ops(0, 4'h1, 4'h2, 4'h3, 4'h4);
    req = 4'b0001;
    serve_job("single", 4'b0001, 4'h1, 4'h2, 4'h3, 4'h4, 5, 16'h00AB, 1'b0, wc);
    req = '0;
    step();
    total_cnt++;
    if ({gnt, busy, done} !== 9'd0)
      $display("FAIL single_after: got gnt=%b busy=%b done=%b expected all 0", gnt, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_pointer_wrap();
    int wc;
    set_ops(2, 4'h5, 4'h6, 4'h7, 4'h8);
    set_ops(0, 4'hD, 4'hE, 4'h0, 4'h1);
    req = 4'b0100;
    serve_job("wrap_r2", 4'b0100, 4'h5, 4'h6, 4'h7, 4'h8, 2, 16'h0202, 1'b0, wc);
    req = 4'b0101;
    serve_job("wrap_r0", 4'b0001, 4'hD, 4'hE, 4'h0, 4'h1, 3, 16'h0303, 1'b0, wc);
    req = '0;
    step();
  endtask

  task automatic test_operand_stability();
    int wc;
    set_ops(0, 4'h3, 4'h9, 4'hC, 4'h6);
    req = 4'b0001;
    // Operands go to all-ones and req drops one cycle after the grant.
    serve_job("snapshot", 4'b0001, 4'h3, 4'h9, 4'hC, 4'h6, 4, 16'hBEEF, 1'b1, wc);
    req = '0;
    req_x = '0; req_dx = '0; req_u = '0; req_a = '0;
    step();
  endtask

  task automatic test_reset_mid_job();
    int wc;
    set_ops(2, 4'h7, 4'h7, 4'h7, 4'h7);
    set_ops(0, 4'h2, 4'h4, 4'h6, 4'h8);
    set_ops(1, 4'hA, 4'hB, 4'hC, 4'hD);
    req = 4'b0100;
    #1;
    total_cnt++;
    if (gnt !== 4'b0100)
      $display("FAIL rst_mid grant: got %b expected 0100", gnt);
    else pass_cnt++;
    repeat (6) step();
    reset = 1'b1;
    #1;
    total_cnt++;
    if (all_out !== 36'd0)
      $display("FAIL rst_mid outputs: got %h expected 000000000", all_out);
    else pass_cnt++;
    req = 4'b0011;
    step();
    step();
    total_cnt++;
    if ({gnt, done, busy} !== 9'd0)
      $display("FAIL rst_mid held: got gnt=%b done=%b busy=%b expected all 0", gnt, done, busy);
    else pass_cnt++;
    reset = 1'b0;
    serve_job("post_reset", 4'b0001, 4'h2, 4'h4, 4'h6, 4'h8, 3, 16'h7E57, 1'b0, wc);
    req = '0;
    step();
  endtask

`ifdef DIFF_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    set_ops(1, 4'h1, 4'h1, 4'h1, 4'h1);
    req = 4'b0010;
    #1;
    total_cnt++;
    if (gnt !== 4'b0010)
      $display("FAIL timeout grant: got %b expected 0010", gnt);
    else pass_cnt++;
    n = 0;
    while (done == '0 && n < 60) begin
      step();
      n++;
    end
    total_cnt++;
    if ({n[7:0], done, result, err_timeout, eng_reset} !== {8'd21, 4'b0010, 16'h0000, 1'b1, 1'b1})
      $display("FAIL timeout abort: got cycle=%0d done=%b result=%h err=%b eng_reset=%b expected cycle=21 done=0010 result=0000 err=1 eng_reset=1",
               n, done, result, err_timeout, eng_reset);
    else pass_cnt++;
    req = '0;
    step();
    total_cnt++;
    if ({done, err_timeout, eng_reset, busy} !== 7'd0)
      $display("FAIL timeout idle: got done=%b err=%b eng_reset=%b busy=%b expected all 0",
               done, err_timeout, eng_reset, busy);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    set_ops(1, 4'h1, 4'h1, 4'h1, 4'h1);
    req = 4'b0010;
    #1;
    total_cnt++;
    if (gnt !== 4'b0010)
      $display("FAIL no_timeout grant: got %b expected 0010", gnt);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if ({done, err_timeout, eng_reset, busy} !== 7'b0000001) bad++;
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL no_timeout wait: got %0d bad cycles expected 0", bad);
    else pass_cnt++;
    eng_valid = 1'b1;
    eng_out = 16'h5A5A;
    step();
    eng_valid = 1'b0;
    eng_out = '0;
    total_cnt++;
    if ({done, result, err_timeout, eng_reset} !== {4'b0010, 16'h5A5A, 1'b0, 1'b0})
      $display("FAIL no_timeout done: got done=%b result=%h err=%b eng_reset=%b expected done=0010 result=5a5a err=0 eng_reset=0",
               done, result, err_timeout, eng_reset);
    else pass_cnt++;
    req = '0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_job();
    test_pointer_wrap();
    test_operand_stability();
    test_reset_mid_job();
`ifdef DIFF_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
